// File: rtl/ahb_arb_pkg.sv
// Shared AHB encodings and burst-length helper for the bus-matrix output-stage arbiters.
package ahb_arb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_INCR   = 3'b001;
    localparam logic [2:0] HBURST_WRAP4  = 3'b010;
    localparam logic [2:0] HBURST_INCR4  = 3'b011;
    localparam logic [2:0] HBURST_WRAP8  = 3'b100;
    localparam logic [2:0] HBURST_INCR8  = 3'b101;
    localparam logic [2:0] HBURST_WRAP16 = 3'b110;
    localparam logic [2:0] HBURST_INCR16 = 3'b111;

    // Beats left after the NONSEQ before the final beat; the final beat itself releases hold.
    // Undefined-length INCR is treated like a 4-beat burst.
    function automatic logic [3:0] burst_remain_init(input logic [2:0] hburst);
        case (hburst)
            HBURST_INCR16, HBURST_WRAP16:             return 4'd14;
            HBURST_INCR8,  HBURST_WRAP8:              return 4'd6;
            HBURST_INCR4,  HBURST_WRAP4, HBURST_INCR: return 4'd2;
            default:                                  return 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/ahb_burst_tracker.sv
// Tracks the beats of the current fixed-length burst and reports whether the grant must be held.
module ahb_burst_tracker
    import ahb_arb_pkg::*;
(
    input  logic       HCLK,
    input  logic       HRESETn,
    input  logic       HREADYM,
    input  logic       HSELM,
    input  logic [1:0] HTRANSM,
    input  logic [2:0] HBURSTM,
    output logic       next_hold
);

    logic [3:0] remain;
    logic [3:0] next_remain;
    logic       hold;

    always_comb begin
        next_remain = remain;
        next_hold   = hold;
        if (!HSELM) begin
            next_remain = '0;
            next_hold   = 1'b0;
        end else begin
            case (HTRANSM)
                HTRANS_IDLE: begin
                    next_remain = '0;
                    next_hold   = 1'b0;
                end
                HTRANS_BUSY: begin
                end
                HTRANS_NONSEQ: begin
                    next_remain = burst_remain_init(HBURSTM);
                    next_hold   = (HBURSTM != HBURST_SINGLE);
                end
                HTRANS_SEQ: begin
                    if (remain == '0)
                        next_hold = 1'b0;
                    else
                        next_remain = remain - 4'd1;
                end
            endcase
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            remain <= '0;
            hold   <= 1'b0;
        end else if (HREADYM) begin
            remain <= next_remain;
            hold   <= next_hold;
        end
    end

endmodule

// File: rtl/ahb_wrr_arbiter.sv
// Weighted round-robin arbiter for one bus-matrix output stage; grants are held across
// fixed-length bursts and locked sequences.
module ahb_wrr_arbiter
    import ahb_arb_pkg::*;
#(
    parameter int NPORTS = 4,
    parameter int PW     = 2,
    parameter int WW     = 4
) (
    input  logic                 HCLK,
    input  logic                 HRESETn,
    input  logic [NPORTS-1:0]    req,
    input  logic                 HREADYM,
    input  logic                 HSELM,
    input  logic [1:0]           HTRANSM,
    input  logic [2:0]           HBURSTM,
    input  logic                 HMASTLOCKM,
    input  logic [NPORTS*WW-1:0] weight_cfg,
    output logic [PW-1:0]        addr_in_port,
    output logic                 no_port,
    output logic [NPORTS-1:0]    grant_vec
);

    localparam logic [WW-1:0] CREDIT_ONE = WW'(1);

    if (PW != $clog2(NPORTS)) begin : g_pw_check
        $error("ahb_wrr_arbiter: PW must equal clog2(NPORTS)");
    end

    logic                next_hold;
    logic [WW-1:0]       weight [NPORTS];
    logic [WW-1:0]       credit [NPORTS];
    logic [WW-1:0]       credit_cur;
    logic [WW-1:0]       credit_after;
    logic [WW-1:0]       pick_credit;
    logic                owner_xfer;
    logic                arb_point;
    logic                keep_owner;
    logic                found;
    logic [PW-1:0]       pick;
    logic [NPORTS-1:0]   pick_onehot;

    for (genvar g = 0; g < NPORTS; g++) begin : g_weight
        assign weight[g] = weight_cfg[g*WW +: WW];
    end

    ahb_burst_tracker u_burst (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .HREADYM   (HREADYM),
        .HSELM     (HSELM),
        .HTRANSM   (HTRANSM),
        .HBURSTM   (HBURSTM),
        .next_hold (next_hold)
    );

    // The keep decision uses the credit as it will be after this beat's NONSEQ is charged.
    assign credit_cur   = credit[addr_in_port];
    assign owner_xfer   = HSELM && (HTRANSM == HTRANS_NONSEQ) && !no_port;
    assign credit_after = (owner_xfer && credit_cur != '0) ? credit_cur - CREDIT_ONE : credit_cur;
    assign arb_point    = HREADYM && !HMASTLOCKM && !next_hold;
    assign keep_owner   = !no_port && req[addr_in_port] && (credit_after != '0);
    assign pick_credit  = (weight[pick] == '0) ? CREDIT_ONE : weight[pick];

    // Rotating search from the port after the owner; fixed priority from port 0 when idle.
    always_comb begin
        int base;
        int idx;
        found       = 1'b0;
        pick        = addr_in_port;
        pick_onehot = '0;
        base        = no_port ? 0 : int'(addr_in_port) + 1;
        for (int k = 0; k < NPORTS; k++) begin
            idx = (base + k) % NPORTS;
            if (!found && req[idx[PW-1:0]]) begin
                found = 1'b1;
                pick  = idx[PW-1:0];
            end
        end
        pick_onehot[pick] = 1'b1;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            addr_in_port <= '0;
            no_port      <= 1'b1;
            grant_vec    <= '0;
            for (int i = 0; i < NPORTS; i++)
                credit[i] <= '0;
        end else if (HREADYM) begin
            credit[addr_in_port] <= credit_after;
            if (arb_point && !keep_owner) begin
                if (found) begin
                    addr_in_port <= pick;
                    no_port      <= 1'b0;
                    grant_vec    <= pick_onehot;
                    credit[pick] <= pick_credit;
                end else if (no_port || !HSELM) begin
                    // Nothing requesting and the slave is not selected: release the port.
                    no_port   <= 1'b1;
                    grant_vec <= '0;
                end
            end
        end
    end

`ifndef SYNTHESIS
    a_legal_port: assert property (@(posedge HCLK) disable iff (!HRESETn)
        int'(addr_in_port) < NPORTS)
        else $error("ahb_wrr_arbiter: addr_in_port %0d out of range", addr_in_port);

    a_grant_onehot: assert property (@(posedge HCLK) disable iff (!HRESETn)
        grant_vec == (no_port ? '0 : (NPORTS'(1) << addr_in_port)))
        else $error("ahb_wrr_arbiter: grant_vec %b inconsistent with addr_in_port", grant_vec);
`endif

endmodule

// File: tb/tb_ahb_wrr_arbiter.sv
// Bench for ahb_wrr_arbiter: directed scenarios plus randomized traffic against a beat-level model.
module tb_ahb_wrr_arbiter;
    import ahb_arb_pkg::*;

    localparam int NPORTS = 4;
    localparam int PW     = 2;
    localparam int WW     = 4;

    logic                 HCLK = 1'b0;
    logic                 HRESETn;
    logic [NPORTS-1:0]    req;
    logic                 HREADYM;
    logic                 HSELM;
    logic [1:0]           HTRANSM;
    logic [2:0]           HBURSTM;
    logic                 HMASTLOCKM;
    logic [NPORTS*WW-1:0] weight_cfg;
    logic [PW-1:0]        addr_in_port;
    logic                 no_port;
    logic [NPORTS-1:0]    grant_vec;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    int m_owner;
    bit m_none;
    int m_beats;
    int m_credit [NPORTS];

    ahb_wrr_arbiter #(.NPORTS(NPORTS), .PW(PW), .WW(WW)) dut (
        .HCLK         (HCLK),
        .HRESETn      (HRESETn),
        .req          (req),
        .HREADYM      (HREADYM),
        .HSELM        (HSELM),
        .HTRANSM      (HTRANSM),
        .HBURSTM      (HBURSTM),
        .HMASTLOCKM   (HMASTLOCKM),
        .weight_cfg   (weight_cfg),
        .addr_in_port (addr_in_port),
        .no_port      (no_port),
        .grant_vec    (grant_vec)
    );

    always #5 HCLK = ~HCLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int burst_len(input logic [2:0] hb);
        case (hb)
            HBURST_SINGLE:               return 1;
            HBURST_INCR8, HBURST_WRAP8:   return 8;
            HBURST_INCR16, HBURST_WRAP16: return 16;
            default:                      return 4;
        endcase
    endfunction

    task automatic model_reset();
        m_owner = 0;
        m_none  = 1'b1;
        m_beats = 0;
        for (int i = 0; i < NPORTS; i++) m_credit[i] = 0;
    endtask

    // One accepted beat: beats are counted down from the burst length, the owner is charged
    // for each NONSEQ, then the grant is re-decided if no burst or lock pins it.
    task automatic model_step();
        int w;
        int start;
        int p;
        if (!HREADYM) return;
        if (!HSELM || HTRANSM == HTRANS_IDLE) m_beats = 0;
        else if (HTRANSM == HTRANS_NONSEQ)    m_beats = burst_len(HBURSTM) - 1;
        else if (HTRANSM == HTRANS_SEQ && m_beats > 0) m_beats--;
        if (HSELM && HTRANSM == HTRANS_NONSEQ && !m_none && m_credit[m_owner] > 0)
            m_credit[m_owner]--;
        if (HMASTLOCKM || m_beats > 0) return;
        if (!m_none && req[m_owner[PW-1:0]] && m_credit[m_owner] > 0) return;
        if (req != '0) begin
            start = m_none ? 0 : m_owner + 1;
            p = -1;
            for (int k = 0; k < NPORTS; k++)
                if (p < 0 && req[(start + k) % NPORTS]) p = (start + k) % NPORTS;
            m_owner = p;
            m_none  = 1'b0;
            w = int'((weight_cfg >> (p * WW)) & 16'hF);
            m_credit[p] = (w == 0) ? 1 : w;
        end else if (m_none || !HSELM) begin
            m_none = 1'b1;
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, ".addr"},  32'(addr_in_port), 32'(m_owner));
        check({tag, ".none"},  32'(no_port),      32'(m_none));
        check({tag, ".grant"}, 32'(grant_vec),    m_none ? 32'd0 : (32'd1 << m_owner));
    endtask

    task automatic cycle(input string tag);
        @(posedge HCLK);
        if (!HRESETn) model_reset();
        else model_step();
        #1;
        check_model(tag);
    endtask

    task automatic drive(input logic [3:0] r, input logic sel, input logic [1:0] tr,
                         input logic [2:0] hb, input logic rdy, input logic lk);
        req = r; HSELM = sel; HTRANSM = tr; HBURSTM = hb; HREADYM = rdy; HMASTLOCKM = lk;
    endtask

    task automatic do_reset();
        HRESETn = 1'b0;
        cycle("rst");
        HRESETn = 1'b1;
    endtask

    logic [3:0] t2_exp [8];
    logic [1:0] t3_tr  [10];
    logic       t3_rdy [10];

    initial begin
        HRESETn    = 1'b0;
        weight_cfg = 16'h1111;
        drive(4'b0110, 1'b0, HTRANS_IDLE, HBURST_SINGLE, 1'b1, 1'b0);
        model_reset();

        // Reset values, then first grant with req=0110 held through reset
        cycle("t1.rst");
        check("t1.rst_none",  32'(no_port),      32'd1);
        check("t1.rst_grant", 32'(grant_vec),    32'd0);
        check("t1.rst_addr",  32'(addr_in_port), 32'd0);
        HRESETn = 1'b1;
        cycle("t1");
        check("t1.addr",  32'(addr_in_port), 32'd1);
        check("t1.none",  32'(no_port),      32'd0);
        check("t1.grant", 32'(grant_vec),    32'b0010);

        // Weighted sharing: port 0 weight 3, port 1 weight 1
        do_reset();
        weight_cfg = {4'd1, 4'd1, 4'd1, 4'd3};
        drive(4'b0011, 1'b1, HTRANS_NONSEQ, HBURST_SINGLE, 1'b1, 1'b0);
        t2_exp = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd0, 4'd0, 4'd0, 4'd1};
        for (int i = 0; i < 8; i++) begin
            cycle("t2");
            check($sformatf("t2.seq%0d", i), 32'(addr_in_port), 32'(t2_exp[i]));
        end

        // INCR8 from port 2 with BUSY and a wait state, everyone else requesting
        do_reset();
        weight_cfg = 16'h1111;
        drive(4'b0100, 1'b0, HTRANS_IDLE, HBURST_SINGLE, 1'b1, 1'b0);
        cycle("t3.own");
        check("t3.own", 32'(addr_in_port), 32'd2);
        t3_tr  = '{HTRANS_NONSEQ, HTRANS_SEQ, HTRANS_SEQ, HTRANS_BUSY, HTRANS_SEQ,
                   HTRANS_SEQ, HTRANS_SEQ, HTRANS_SEQ, HTRANS_SEQ, HTRANS_SEQ};
        t3_rdy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 10; i++) begin
            drive(4'b1111, 1'b1, t3_tr[i], HBURST_INCR8, t3_rdy[i], 1'b0);
            cycle("t3");
            check($sformatf("t3.beat%0d", i), 32'(addr_in_port), (i == 9) ? 32'd3 : 32'd2);
        end

        // Lock overrides exhausted credit (owner 3, credit 1)
        for (int i = 0; i < 3; i++) begin
            drive(4'b1111, 1'b1, HTRANS_NONSEQ, HBURST_SINGLE, 1'b1, 1'b1);
            cycle("t4");
            check($sformatf("t4.lock%0d", i), 32'(addr_in_port), 32'd3);
        end
        drive(4'b1111, 1'b1, HTRANS_IDLE, HBURST_SINGLE, 1'b1, 1'b0);
        cycle("t4.unlock");
        check("t4.unlock", 32'(addr_in_port), 32'd0);

        // Parking on the owner, then release when deselected
        drive(4'b0100, 1'b1, HTRANS_IDLE, HBURST_SINGLE, 1'b1, 1'b0);
        cycle("t5.own");
        check("t5.own", 32'(addr_in_port), 32'd2);
        drive(4'b0000, 1'b1, HTRANS_IDLE, HBURST_SINGLE, 1'b1, 1'b0);
        cycle("t5.park");
        cycle("t5.park");
        check("t5.park_none",  32'(no_port),   32'd0);
        check("t5.park_grant", 32'(grant_vec), 32'b0100);
        drive(4'b0000, 1'b0, HTRANS_IDLE, HBURST_SINGLE, 1'b1, 1'b0);
        cycle("t5.rel");
        check("t5.rel_none",  32'(no_port),      32'd1);
        check("t5.rel_grant", 32'(grant_vec),    32'd0);
        check("t5.rel_addr",  32'(addr_in_port), 32'd2);

        // Asynchronous reset in the middle of a WRAP16
        drive(4'b0010, 1'b0, HTRANS_IDLE, HBURST_SINGLE, 1'b1, 1'b0);
        cycle("t6.own");
        check("t6.own", 32'(addr_in_port), 32'd1);
        drive(4'b1111, 1'b1, HTRANS_NONSEQ, HBURST_WRAP16, 1'b1, 1'b0);
        cycle("t6.burst");
        HTRANSM = HTRANS_SEQ;
        for (int i = 0; i < 5; i++) cycle("t6.burst");
        #3 HRESETn = 1'b0;
        #1;
        model_reset();
        check("t6.rst_none",  32'(no_port),      32'd1);
        check("t6.rst_addr",  32'(addr_in_port), 32'd0);
        check("t6.rst_grant", 32'(grant_vec),    32'd0);
        cycle("t6.rst");
        HRESETn = 1'b1;
        drive(4'b1000, 1'b1, HTRANS_SEQ, HBURST_WRAP16, 1'b1, 1'b0);
        cycle("t6.after");
        check("t6.after_addr", 32'(addr_in_port), 32'd3);
        check("t6.after_none", 32'(no_port),      32'd0);

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            int r;
            if (i % 250 == 0) weight_cfg = 16'($urandom);
            r = $urandom_range(0, 99);
            if (m_beats > 0)
                HTRANSM = (r < 70) ? HTRANS_SEQ : (r < 85) ? HTRANS_BUSY :
                          (r < 92) ? HTRANS_NONSEQ : HTRANS_IDLE;
            else
                HTRANSM = (r < 50) ? HTRANS_NONSEQ : (r < 75) ? HTRANS_IDLE :
                          (r < 90) ? HTRANS_BUSY : HTRANS_SEQ;
            HBURSTM    = 3'($urandom_range(0, 7));
            req        = ($urandom_range(0, 99) < 15) ? 4'b0000 : 4'($urandom_range(0, 15));
            HSELM      = ($urandom_range(0, 99) < 90);
            HREADYM    = ($urandom_range(0, 99) < 85);
            HMASTLOCKM = ($urandom_range(0, 99) < 10);
            HRESETn    = (i % 997 != 500);
            cycle("rnd");
        end
        HRESETn = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
